cpu15_phase_ctl: RTL and testbench



---
 rtl/cpu15_pkg.sv | 34 +++
 rtl/cpu15_ex_timer.sv | 28 ++
 rtl/cpu15_phase_ctl.sv | 124 ++++++++++++
 tb/tb_cpu15_phase_ctl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu15_pkg.sv
// Shared phase encoding and clock-enable bit positions for the 15-bit CPU sequencer,
// also consumed by debug/trace logic.
package cpu15_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_WBACK  = 3'd4,
        PH_HALT   = 3'd5
    } phase_e;

    localparam int CE_W      = 4;
    localparam int CE_FT_BIT = 0;
    localparam int CE_DC_BIT = 1;
    localparam int CE_EX_BIT = 2;
    localparam int CE_WB_BIT = 3;

    // One-hot stage enable for a phase; IDLE, HALT and illegal codes enable nothing.
    function automatic logic [CE_W-1:0] ce_of(input phase_e ph);
        logic [CE_W-1:0] ce;
        ce = '0;
        case (ph)
            PH_FETCH:  ce[CE_FT_BIT] = 1'b1;
            PH_DECODE: ce[CE_DC_BIT] = 1'b1;
            PH_EXEC:   ce[CE_EX_BIT] = 1'b1;
            PH_WBACK:  ce[CE_WB_BIT] = 1'b1;
            default:   ce = '0;
        endcase
        return ce;
    endfunction

endpackage

// File: rtl/cpu15_ex_timer.sv
// Counts busy cycles spent in EXEC; expire flags the last cycle allowed before error-halt.
module cpu15_ex_timer
    import cpu15_pkg::*;
#(
    parameter int unsigned EX_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic N_RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] busy_cnt;

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            busy_cnt <= '0;
        end else if (clr) begin
            busy_cnt <= '0;
        end else if (en && !expire) begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end

    assign expire = (busy_cnt == 8'(EX_TIMEOUT - 1));

endmodule

// File: rtl/cpu15_phase_ctl.sv
// Instruction-phase sequencer: one-hot stage enables, run/stop, HALT, EXEC stall timeout.
// Optional single-step input STEP when CPU15_SINGLE_STEP_EN is defined.
module cpu15_phase_ctl
    import cpu15_pkg::*;
#(
    parameter int unsigned EX_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             N_RST,
    input  logic             RUN,
    input  logic             CLR,
    input  logic             HALT_REQ,
    input  logic             EX_BUSY,
`ifdef CPU15_SINGLE_STEP_EN
    input  logic             STEP,
`endif
    output logic             CE_FT,
    output logic             CE_DC,
    output logic             CE_EX,
    output logic             CE_WB,
    output logic [2:0]       PHASE,
    output logic             HALTED,
    output logic             ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    phase_e            state_q, state_d;
    logic [CE_W-1:0]   ce_q;
    logic              halted_q;
    logic              err_q;
    logic              err_set;
    logic [CNT_W-1:0]  cnt_q;
    logic              step_rise;
    logic              tmr_clr, tmr_en, tmr_expire;

`ifdef CPU15_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            step_q <= 1'b0;
        end else begin
            step_q <= STEP;
        end
    end

    assign step_rise = STEP & ~step_q;
`else
    assign step_rise = 1'b0;
`endif

    // Timer is held clear outside EXEC, so each instruction's stall budget starts fresh.
    assign tmr_clr = (state_q != PH_EXEC);
    assign tmr_en  = (state_q == PH_EXEC) && EX_BUSY;

    cpu15_ex_timer #(
        .EX_TIMEOUT(EX_TIMEOUT)
    ) u_ex_timer (
        .CLK   (CLK),
        .N_RST (N_RST),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            PH_IDLE:   if (RUN || step_rise) state_d = PH_FETCH;
            PH_FETCH:  state_d = PH_DECODE;
            PH_DECODE: state_d = PH_EXEC;
            PH_EXEC: begin
                if (!EX_BUSY) begin
                    state_d = PH_WBACK;
                end else if (tmr_expire) begin
                    state_d = PH_HALT;
                    err_set = 1'b1;
                end
            end
            PH_WBACK: begin
                if (HALT_REQ)  state_d = PH_HALT;
                else if (RUN)  state_d = PH_FETCH;
                else           state_d = PH_IDLE;
            end
            PH_HALT:   state_d = PH_HALT;
            default:   state_d = PH_IDLE;
        endcase
        if (CLR) begin
            state_d = PH_IDLE;
            err_set = 1'b0;
        end
    end

    // Enables and HALTED are registered from the next state so they track state_q exactly.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q  <= PH_IDLE;
            ce_q     <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_of(state_d);
            halted_q <= (state_d == PH_HALT);
            err_q    <= CLR ? 1'b0 : (err_q | err_set);
            if (state_q == PH_WBACK) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign CE_FT     = ce_q[CE_FT_BIT];
    assign CE_DC     = ce_q[CE_DC_BIT];
    assign CE_EX     = ce_q[CE_EX_BIT];
    assign CE_WB     = ce_q[CE_WB_BIT];
    assign PHASE     = state_q;
    assign HALTED    = halted_q;
    assign ERR       = err_q;
    assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu15_phase_ctl.sv
// Self-checking bench for cpu15_phase_ctl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the phase sequencer.
module tb_cpu15_phase_ctl;

    localparam int EX_TIMEOUT = 16;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             run = 1'b0;
    logic             clr = 1'b0;
    logic             halt_req = 1'b0;
    logic             ex_busy = 1'b0;
    logic             step = 1'b0;
    logic             ce_ft, ce_dc, ce_ex, ce_wb, halted, err;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: phase number 0..5, busy cycles spent in the current execute,
    // retired count modulo 2^CNT_W, sticky error.
    int m_phase = 0;
    int m_spent = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    bit m_step_q = 1'b0;
    bit m_rise;
    int m_next;

    always #5 clk = ~clk;

    cpu15_phase_ctl #(
        .EX_TIMEOUT(EX_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK      (clk),
        .N_RST    (n_rst),
        .RUN      (run),
        .CLR      (clr),
        .HALT_REQ (halt_req),
        .EX_BUSY  (ex_busy),
`ifdef CPU15_SINGLE_STEP_EN
        .STEP     (step),
`endif
        .CE_FT    (ce_ft),
        .CE_DC    (ce_dc),
        .CE_EX    (ce_ex),
        .CE_WB    (ce_wb),
        .PHASE    (phase),
        .HALTED   (halted),
        .ERR      (err),
        .INSTR_CNT(instr_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!n_rst) begin
            m_phase = 0; m_spent = 0; m_cnt = 0; m_err = 1'b0; m_step_q = 1'b0;
        end else begin
            m_rise = 1'b0;
`ifdef CPU15_SINGLE_STEP_EN
            m_rise = step && !m_step_q;
            m_step_q = step;
`endif
            m_next = m_phase;
            if (m_phase == 4) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (clr) begin
                m_next = 0;
                m_err  = 1'b0;
            end else begin
                case (m_phase)
                    0: if (run || m_rise) m_next = 1;
                    1: m_next = 2;
                    2: m_next = 3;
                    3: begin
                        if (!ex_busy) m_next = 4;
                        else if (m_spent + 1 >= EX_TIMEOUT) begin
                            m_next = 5;
                            m_err  = 1'b1;
                        end
                    end
                    4: m_next = halt_req ? 5 : (run ? 1 : 0);
                    default: m_next = m_phase;
                endcase
            end
            m_spent = (m_phase == 3 && m_next == 3) ? m_spent + 1 : 0;
            m_phase = m_next;
        end
        #1;
        if (chk_en) begin
            check("phase", int'(phase), m_phase);
            check("ce_onehot", int'({ce_wb, ce_ex, ce_dc, ce_ft}),
                  (m_phase >= 1 && m_phase <= 4) ? (1 << (m_phase - 1)) : 0);
            check("halted", int'(halted), int'(m_phase == 5));
            check("err", int'(err), int'(m_err));
            check("instr_cnt", int'(instr_cnt), m_cnt);
        end
    end

    initial begin
        int ex_seen;
        int wb_seen;
        bit stuck;

        repeat (2) @(negedge clk);
        check("reset_phase", int'(phase), 0);
        check("reset_ce", int'({ce_wb, ce_ex, ce_dc, ce_ft}), 0);
        check("reset_cnt", int'(instr_cnt), 0);
        n_rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Three back-to-back instructions, RUN dropped during the third write-back.
        run = 1'b1;
        repeat (12) @(negedge clk);
        check("three_instr_in_wb", int'(ce_wb), 1);
        run = 1'b0;
        @(negedge clk);
        check("three_instr_cnt", int'(instr_cnt), 3);
        check("three_instr_idle", int'(phase), 0);

        // Execute stall of five busy cycles.
        run = 1'b1; ex_busy = 1'b1;
        @(negedge clk);
        run = 1'b0;
        ex_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ce_ex) ex_seen++;
            ex_busy = (ex_seen <= 5);
            if (phase == 3'd0) break;
        end
        ex_busy = 1'b0;
        check("stall_done", int'(phase), 0);
        check("stall_ex_cycles", ex_seen, 6);
        check("stall_cnt", int'(instr_cnt), 4);
        check("stall_err", int'(err), 0);

        // Execute stuck busy until timeout.
        run = 1'b1; ex_busy = 1'b1;
        ex_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ce_ex) ex_seen++;
            if (halted) break;
        end
        check("timeout_ex_cycles", ex_seen, 16);
        check("timeout_halted", int'(halted), 1);
        check("timeout_err", int'(err), 1);
        check("timeout_phase", int'(phase), 5);
        check("timeout_cnt", int'(instr_cnt), 4);
        ex_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            @(negedge clk);
        end
        check("timeout_hold", int'(phase), 5);
        run = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_phase", int'(phase), 0);
        check("clr_err", int'(err), 0);
        check("clr_halted", int'(halted), 0);

        // HALT instruction retired at the second write-back.
        run = 1'b1;
        wb_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) break;
            if (ce_wb) begin
                wb_seen++;
                if (wb_seen == 2) halt_req = 1'b1;
            end
        end
        halt_req = 1'b0;
        check("haltreq_phase", int'(phase), 5);
        check("haltreq_cnt", int'(instr_cnt), 6);
        for (int i = 0; i < 5; i++) begin
            run = ~run;
            @(negedge clk);
        end
        check("haltreq_hold", int'(phase), 5);
        run = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("haltreq_clr", int'(phase), 0);

        // Asynchronous reset in the middle of execute.
        run = 1'b1; ex_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("areset_in_exec", int'(ce_ex), 1);
        #2 n_rst = 1'b0;
        #1;
        check("areset_ce", int'({ce_wb, ce_ex, ce_dc, ce_ft}), 0);
        check("areset_phase", int'(phase), 0);
        check("areset_cnt", int'(instr_cnt), 0);
        run = 1'b0; ex_busy = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("areset_stay_idle", int'(phase), 0);

        // Seventeen instructions wrap the 4-bit counter.
        run = 1'b1;
        repeat (68) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("wrap_cnt", int'(instr_cnt), 1);
        check("wrap_idle", int'(phase), 0);

`ifdef CPU15_SINGLE_STEP_EN
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (6) @(negedge clk);
            check("step_idle", int'(phase), 0);
        end
        check("step_cnt", int'(instr_cnt), 3);
`endif

        // Randomized traffic; the per-cycle model comparison does the checking.
        stuck = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(199) == 0) stuck = ~stuck;
            run      = ($urandom_range(9) < 7);
            clr      = ($urandom_range(49) == 0);
            halt_req = ($urandom_range(9) == 0);
            ex_busy  = stuck | $urandom_range(1);
            step     = ($urandom_range(3) == 0);
        end
        run = 1'b0; clr = 1'b0; halt_req = 1'b0; ex_busy = 1'b0; step = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
